// File: rtl/audio_mixer_nch.sv
// audio_mixer_nch: N-channel panned audio mixer with tape injection, master attenuation
// and per-side first-order sigma-delta 1-bit outputs.
module audio_mixer_nch #(
    parameter int NCH = 3,
    parameter int W = 8,
    parameter logic [W-1:0] MIC_LVL = 8'h40,
    parameter logic [W-1:0] EAR_LVL = 8'h40,
    localparam int ACCW = W + $clog2(NCH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_stb,
    input  logic [NCH*W-1:0] ch_in,
    input  logic [2*NCH-1:0] pan,
    input  logic             mic,
    input  logic             ear,
    input  logic [2:0]       att,
    output logic [ACCW-1:0]  pcm_l,
    output logic [ACCW-1:0]  pcm_r,
    output logic             pcm_valid,
    output logic             busy,
    output logic             overrun,
    output logic             audio_out_left,
    output logic             audio_out_right
);
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCALE, S_LOAD} state_t;

    state_t            r_state, w_next;
    logic [NCH*W-1:0]  r_ch;
    logic [2*NCH-1:0]  r_pan;
    logic [2:0]        r_att;
    logic [IW-1:0]     r_idx;
    logic [ACCW-1:0]   r_sum_l, r_sum_r, r_pcm_l, r_pcm_r;
    logic              r_overrun;
    logic [ACCW:0]     r_sd_l, r_sd_r;
    logic [W-1:0]      w_ch;
    logic [1:0]        w_pan;
    logic [ACCW-1:0]   w_tape;

    assign w_ch   = r_ch[r_idx*W +: W];
    assign w_pan  = r_pan[r_idx*2 +: 2];
    assign w_tape = (mic ? ACCW'(MIC_LVL) : '0) + (ear ? ACCW'(EAR_LVL) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = sample_stb ? S_ACCUM : S_IDLE;
            S_ACCUM: w_next = (r_idx == IW'(NCH - 1)) ? S_SCALE : S_ACCUM;
            S_SCALE: w_next = S_LOAD;
            S_LOAD:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch      <= '0;
            r_pan     <= '0;
            r_att     <= '0;
            r_idx     <= '0;
            r_sum_l   <= '0;
            r_sum_r   <= '0;
            r_pcm_l   <= '0;
            r_pcm_r   <= '0;
            r_overrun <= 1'b0;
            r_sd_l    <= '0;
            r_sd_r    <= '0;
        end else begin
            // A strobe is only honoured in IDLE; anywhere else it is flagged and dropped.
            r_overrun <= sample_stb && (r_state != S_IDLE);
            unique case (r_state)
                S_IDLE: if (sample_stb) begin
                    r_ch    <= ch_in;
                    r_pan   <= pan;
                    r_att   <= att;
                    r_idx   <= '0;
                    r_sum_l <= w_tape;
                    r_sum_r <= w_tape;
                end
                S_ACCUM: begin
                    if (w_pan[0]) r_sum_l <= r_sum_l + ACCW'(w_ch);
                    if (w_pan[1]) r_sum_r <= r_sum_r + ACCW'(w_ch);
                    r_idx <= r_idx + IW'(1);
                end
                S_SCALE: begin
                    r_sum_l <= r_sum_l >> r_att;
                    r_sum_r <= r_sum_r >> r_att;
                end
                S_LOAD: begin
                    r_pcm_l <= r_sum_l;
                    r_pcm_r <= r_sum_r;
                end
                default: ;
            endcase
            // Carry out of the ACCW-bit residual is the 1-bit DAC output.
            r_sd_l <= {1'b0, r_sd_l[ACCW-1:0]} + {1'b0, r_pcm_l};
            r_sd_r <= {1'b0, r_sd_r[ACCW-1:0]} + {1'b0, r_pcm_r};
        end
    end

    assign pcm_l           = r_pcm_l;
    assign pcm_r           = r_pcm_r;
    assign pcm_valid       = (r_state == S_LOAD);
    assign busy            = (r_state != S_IDLE);
    assign overrun         = r_overrun;
    assign audio_out_left  = r_sd_l[ACCW];
    assign audio_out_right = r_sd_r[ACCW];
endmodule

// File: tb/tb_audio_mixer_nch.sv
// tb_audio_mixer_nch: directed bench for audio_mixer_nch (NCH=3, W=8, ACCW=11)
// with hand-computed mix results, latency, overrun and sigma-delta density checks.
module tb_audio_mixer_nch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_stb = 1'b0;
    logic [23:0] ch_in = '0;
    logic [5:0]  pan = '0;
    logic        mic = 1'b0;
    logic        ear = 1'b0;
    logic [2:0]  att = '0;
    logic [10:0] pcm_l, pcm_r;
    logic        pcm_valid, busy, overrun, audio_out_left, audio_out_right;
    int          total = 0;
    int          bad = 0;

    audio_mixer_nch dut (
        .clk(clk), .rst_n(rst_n), .sample_stb(sample_stb), .ch_in(ch_in), .pan(pan),
        .mic(mic), .ear(ear), .att(att), .pcm_l(pcm_l), .pcm_r(pcm_r),
        .pcm_valid(pcm_valid), .busy(busy), .overrun(overrun),
        .audio_out_left(audio_out_left), .audio_out_right(audio_out_right)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one strobe cycle, then scrambles all inputs so the mix must rely on captured values.
    task automatic strobe(input logic [23:0] c, input logic [5:0] p, input logic m, input logic e,
                          input logic [2:0] a);
        ch_in = c; pan = p; mic = m; ear = e; att = a; sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        ch_in = ~c; pan = ~p; mic = ~m; ear = ~e; att = ~a;
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0;
        tick(); tick();
        total++; if ({pcm_l, pcm_r} !== 22'd0) begin bad++; $display("FAIL reset_pcm: got %h/%h want 0/0", pcm_l, pcm_r); end
        total++; if ({pcm_valid, busy, overrun} !== 3'b000) begin bad++; $display("FAIL reset_ctl: got %b want 000", {pcm_valid, busy, overrun}); end
        total++; if ({audio_out_left, audio_out_right} !== 2'b00) begin bad++; $display("FAIL reset_aout: got %b want 00", {audio_out_left, audio_out_right}); end
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n += int'(audio_out_left) + int'(audio_out_right);
        end
        total++; if (n !== 0) begin bad++; $display("FAIL sd_zero: got %0d ones want 0", n); end
    endtask

    task automatic test_full_scale;
        strobe(24'hFFFFFF, 6'b111111, 1'b0, 1'b0, 3'd0);
        for (int k = 1; k <= 5; k++) begin
            total++; if (pcm_valid !== logic'(k == 5)) begin bad++; $display("FAIL full_valid_t%0d: got %b want %b", k, pcm_valid, k == 5); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy_t%0d: got %b want 1", k, busy); end
            tick();
        end
        total++; if (pcm_l !== 11'd765 || pcm_r !== 11'd765) begin bad++; $display("FAIL full_pcm: got %0d/%0d want 765/765", pcm_l, pcm_r); end
        total++; if (busy !== 1'b0 || pcm_valid !== 1'b0) begin bad++; $display("FAIL full_idle: got busy=%b valid=%b want 0/0", busy, pcm_valid); end
    endtask

    task automatic test_pan;
        strobe({8'h30, 8'h20, 8'h10}, {2'b10, 2'b11, 2'b01}, 1'b1, 1'b0, 3'd0);
        repeat (5) tick();
        total++; if (pcm_l !== 11'h070 || pcm_r !== 11'h090) begin bad++; $display("FAIL pan_pcm: got %h/%h want 070/090", pcm_l, pcm_r); end
    endtask

    task automatic test_att;
        strobe(24'hFFFFFF, 6'b111111, 1'b0, 1'b0, 3'd3);
        repeat (5) tick();
        total++; if (pcm_l !== 11'd95 || pcm_r !== 11'd95) begin bad++; $display("FAIL att_pcm: got %0d/%0d want 95/95", pcm_l, pcm_r); end
    endtask

    task automatic test_tape;
        strobe(24'hFFFFFF, 6'b000000, 1'b1, 1'b1, 3'd0);
        repeat (5) tick();
        total++; if (pcm_l !== 11'h080 || pcm_r !== 11'h080) begin bad++; $display("FAIL tape_pcm: got %h/%h want 080/080", pcm_l, pcm_r); end
    endtask

    task automatic test_back_to_back;
        strobe({8'h30, 8'h20, 8'h10}, {2'b10, 2'b11, 2'b01}, 1'b1, 1'b0, 3'd0);
        repeat (5) tick();
        strobe({8'h01, 8'h02, 8'h03}, 6'b111111, 1'b0, 1'b1, 3'd1);
        total++; if (overrun !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got overrun=%b busy=%b want 0/1", overrun, busy); end
        repeat (4) tick();
        total++; if (pcm_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", pcm_valid); end
        tick();
        total++; if (pcm_l !== 11'd35 || pcm_r !== 11'd35) begin bad++; $display("FAIL b2b_pcm: got %0d/%0d want 35/35", pcm_l, pcm_r); end
    endtask

    task automatic test_overrun;
        int n;
        strobe({8'h30, 8'h20, 8'h10}, {2'b10, 2'b11, 2'b01}, 1'b1, 1'b0, 3'd0);
        tick();
        ch_in = 24'hFFFFFF; pan = 6'b111111; mic = 1'b1; ear = 1'b1; att = 3'd0; sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
        tick();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_single: got %b want 0", overrun); end
        tick();
        total++; if (pcm_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", pcm_valid); end
        tick();
        total++; if (pcm_l !== 11'h070 || pcm_r !== 11'h090) begin bad++; $display("FAIL ovr_pcm: got %h/%h want 070/090", pcm_l, pcm_r); end
        n = 0;
        repeat (6) begin
            tick();
            n += int'(pcm_valid);
        end
        total++; if (n !== 0) begin bad++; $display("FAIL ovr_extra_valid: got %0d pulses want 0", n); end
    endtask

    task automatic test_overrun_load;
        strobe(24'hFFFFFF, 6'b111111, 1'b0, 1'b0, 3'd0);
        repeat (4) tick();
        ch_in = 24'h000000; pan = 6'b111111; mic = 1'b0; ear = 1'b0; sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        total++; if (overrun !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL load_ovr: got overrun=%b busy=%b want 1/0", overrun, busy); end
        total++; if (pcm_l !== 11'd765) begin bad++; $display("FAIL load_pcm: got %0d want 765", pcm_l); end
    endtask

    task automatic test_sd;
        int nl, nr;
        strobe({8'h30, 8'h20, 8'h10}, {2'b10, 2'b11, 2'b01}, 1'b1, 1'b0, 3'd0);
        repeat (8) tick();
        nl = 0; nr = 0;
        for (int i = 0; i < 2048; i++) begin
            tick();
            nl += int'(audio_out_left);
            nr += int'(audio_out_right);
        end
        total++; if (nl !== 112) begin bad++; $display("FAIL sd_left: got %0d ones want 112", nl); end
        total++; if (nr !== 144) begin bad++; $display("FAIL sd_right: got %0d ones want 144", nr); end
    endtask

    task automatic test_reset_mid;
        int n;
        strobe(24'hFFFFFF, 6'b111111, 1'b1, 1'b1, 3'd0);
        tick();
        rst_n = 1'b0;
        #1;
        total++; if ({pcm_l, pcm_r} !== 22'd0) begin bad++; $display("FAIL mid_pcm: got %h/%h want 0/0", pcm_l, pcm_r); end
        total++; if ({pcm_valid, busy, overrun, audio_out_left, audio_out_right} !== 5'd0) begin bad++; $display("FAIL mid_ctl: got %b want 00000", {pcm_valid, busy, overrun, audio_out_left, audio_out_right}); end
        tick();
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            tick();
            n += int'(pcm_valid);
        end
        total++; if (n !== 0 || pcm_l !== 11'd0) begin bad++; $display("FAIL mid_abandon: got %0d pulses pcm=%0d want 0/0", n, pcm_l); end
        strobe(24'h000000, 6'b000000, 1'b1, 1'b1, 3'd0);
        repeat (4) tick();
        total++; if (pcm_valid !== 1'b1) begin bad++; $display("FAIL mid_fresh_valid: got %b want 1", pcm_valid); end
        tick();
        total++; if (pcm_l !== 11'h080 || pcm_r !== 11'h080) begin bad++; $display("FAIL mid_fresh_pcm: got %h/%h want 080/080", pcm_l, pcm_r); end
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_pan();
        test_att();
        test_tape();
        test_back_to_back();
        test_overrun();
        test_overrun_load();
        test_sd();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
